// File: rtl/clock_pkg.sv
// Shared constants and FSM state type for the clock time-set path.
// Used by the set controller and its bench.
package clock_pkg;

  localparam int HR_W  = 5;
  localparam int MIN_W = 6;

  localparam logic [HR_W-1:0]  HR_MAX_24 = 5'd23;
  localparam logic [HR_W-1:0]  HR_MAX_12 = 5'd11;
  localparam logic [MIN_W-1:0] MIN_MAX   = 6'd59;

  typedef enum logic [1:0] {
    RUN,
    SET_HR,
    SET_MIN,
    COMMIT
  } set_state_e;

  function automatic logic [HR_W-1:0] hr_inc(
    input logic [HR_W-1:0] h,
    input logic [HR_W-1:0] max
  );
    return (h >= max) ? '0 : h + 5'd1;
  endfunction

  function automatic logic [MIN_W-1:0] min_inc(
    input logic [MIN_W-1:0] m
  );
    return (m >= MIN_MAX) ? '0 : m + 6'd1;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button conditioner: 2-FF synchronizer, stability debounce,
// one-cycle rising-edge pulse plus the debounced level.
module btn_sync_edge #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic lvl,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_MS + 1);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = '0;
    lvl_d   = lvl_q;
    pulse_d = 1'b0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CW'(DEBOUNCE_MS - 1)) begin
        lvl_d   = s2_q;
        pulse_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      lvl_q   <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lvl   = lvl_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Two-button time-set controller: freezes the clock counter,
// edits hr/min with auto-repeat, then issues a one-cycle load.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_MS   = 20,
  parameter int REPEAT_DLY_MS = 600,
  parameter int REPEAT_MS     = 150,
  parameter int TIMEOUT_MS    = 10000,
  parameter int BLINK_MS      = 500
) (
  input  logic             kh_clk,
  input  logic             reset,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic             sw_24h,
  input  logic [HR_W-1:0]  cur_hr,
  input  logic [MIN_W-1:0] cur_min,
  output logic             run_en,
  output logic             load,
  output logic [HR_W-1:0]  load_hr,
  output logic [MIN_W-1:0] load_min,
  output logic             hr12_mode,
  output logic [1:0]       blink_sel,
  output logic             blink_on
);

  localparam int RW = $clog2(REPEAT_DLY_MS + 1);
  localparam int IW = $clog2(TIMEOUT_MS + 1);
  localparam int BW = $clog2(BLINK_MS + 1);

  logic mode_p, mode_lvl, inc_p, inc_lvl;

  btn_sync_edge #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_mode (
    .clk   (kh_clk),
    .rst_n (reset),
    .btn   (btn_mode),
    .lvl   (mode_lvl),
    .pulse (mode_p)
  );

  btn_sync_edge #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_inc (
    .clk   (kh_clk),
    .rst_n (reset),
    .btn   (btn_inc),
    .lvl   (inc_lvl),
    .pulse (inc_p)
  );

  set_state_e       state_q, state_d;
  logic [HR_W-1:0]  edit_hr_q, edit_hr_d;
  logic [MIN_W-1:0] edit_min_q, edit_min_d;
  logic [RW-1:0]    rep_q, rep_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
  logic             sw_s1_q, sw_s2_q, sw_prev_q;
  logic             run_en_q, run_en_d;
  logic             load_q, load_d;
  logic [HR_W-1:0]  load_hr_q, load_hr_d;
  logic [MIN_W-1:0] load_min_q, load_min_d;
  logic             hr12_q;
  logic [1:0]       blink_sel_q, blink_sel_d;
  logic             blink_on_q, blink_on_d;

  logic            rep_tick, inc_ev, editing, timeout, sw_fall;
  logic [HR_W-1:0] hr_max;

  always_comb begin
    state_d     = state_q;
    edit_hr_d   = edit_hr_q;
    edit_min_d  = edit_min_q;
    rep_d       = '0;
    idle_d      = '0;
    blink_cnt_d = '0;
    blink_on_d  = 1'b1;
    load_hr_d   = load_hr_q;
    load_min_d  = load_min_q;

    // Holding mode pauses auto-repeat so the field cannot run on mid-step.
    rep_tick = inc_lvl && !mode_lvl && (rep_q == RW'(REPEAT_DLY_MS));
    if (inc_lvl) begin
      if (rep_q != RW'(REPEAT_DLY_MS)) rep_d = rep_q + RW'(1);
      else if (mode_lvl)               rep_d = rep_q;
      else rep_d = RW'(REPEAT_DLY_MS - REPEAT_MS);
    end

    inc_ev  = inc_p || rep_tick;
    hr_max  = sw_s2_q ? HR_MAX_24 : HR_MAX_12;
    sw_fall = sw_prev_q && !sw_s2_q;
    editing = (state_q == SET_HR) || (state_q == SET_MIN);
    timeout = editing && !mode_p && !inc_ev &&
              (idle_q == IW'(TIMEOUT_MS - 1));
    if (editing && !mode_p && !inc_ev) idle_d = idle_q + IW'(1);

    unique case (state_q)
      RUN: begin
        if (mode_p) begin
          state_d    = SET_HR;
          edit_hr_d  = (cur_hr > HR_MAX_24) ? '0 : cur_hr;
          edit_min_d = (cur_min > MIN_MAX) ? '0 : cur_min;
        end
      end
      SET_HR: begin
        if (mode_p)       state_d   = SET_MIN;
        else if (timeout) state_d   = RUN;
        else if (inc_ev)  edit_hr_d = hr_inc(edit_hr_q, hr_max);
      end
      SET_MIN: begin
        if (mode_p)       state_d    = COMMIT;
        else if (timeout) state_d    = RUN;
        else if (inc_ev)  edit_min_d = min_inc(edit_min_q);
      end
      COMMIT: state_d = RUN;
      default: state_d = RUN;
    endcase

    if (sw_fall && editing && (edit_hr_q > HR_MAX_12))
      edit_hr_d = edit_hr_q - 5'd12;

    run_en_d = (state_d == RUN);
    load_d   = (state_d == COMMIT);
    if (state_d == COMMIT) begin
      load_hr_d  = edit_hr_d;
      load_min_d = edit_min_d;
    end

    unique case (1'b1)
      (state_d == SET_HR):  blink_sel_d = 2'b01;
      (state_d == SET_MIN): blink_sel_d = 2'b10;
      default:              blink_sel_d = 2'b00;
    endcase

    // Blink phase restarts on every SET state entry.
    if ((blink_sel_d != 2'b00) && (state_d == state_q)) begin
      blink_on_d  = blink_on_q;
      blink_cnt_d = blink_cnt_q + BW'(1);
      if (blink_cnt_q == BW'(BLINK_MS - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = !blink_on_q;
      end
    end
  end

  always_ff @(posedge kh_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      edit_hr_q   <= '0;
      edit_min_q  <= '0;
      rep_q       <= '0;
      idle_q      <= '0;
      blink_cnt_q <= '0;
      sw_s1_q     <= 1'b0;
      sw_s2_q     <= 1'b0;
      sw_prev_q   <= 1'b0;
      run_en_q    <= 1'b1;
      load_q      <= 1'b0;
      load_hr_q   <= '0;
      load_min_q  <= '0;
      hr12_q      <= 1'b0;
      blink_sel_q <= 2'b00;
      blink_on_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      edit_hr_q   <= edit_hr_d;
      edit_min_q  <= edit_min_d;
      rep_q       <= rep_d;
      idle_q      <= idle_d;
      blink_cnt_q <= blink_cnt_d;
      sw_s1_q     <= sw_24h;
      sw_s2_q     <= sw_s1_q;
      sw_prev_q   <= sw_s2_q;
      run_en_q    <= run_en_d;
      load_q      <= load_d;
      load_hr_q   <= load_hr_d;
      load_min_q  <= load_min_d;
      hr12_q      <= !sw_s2_q;
      blink_sel_q <= blink_sel_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign run_en    = run_en_q;
  assign load      = load_q;
  assign load_hr   = load_hr_q;
  assign load_min  = load_min_q;
  assign hr12_mode = hr12_q;
  assign blink_sel = blink_sel_q;
  assign blink_on  = blink_on_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: expected loads are queued
// by the stimulus and popped by a monitor on every load pulse.
`timescale 1ns/1ps
module tb_clock_set_ctrl;
  import clock_pkg::*;

  logic             kh_clk = 1'b0;
  logic             reset = 1'b0;
  logic             btn_mode = 1'b0;
  logic             btn_inc = 1'b0;
  logic             sw_24h = 1'b1;
  logic [HR_W-1:0]  cur_hr = '0;
  logic [MIN_W-1:0] cur_min = '0;
  logic             run_en, load, hr12_mode, blink_on;
  logic [HR_W-1:0]  load_hr;
  logic [MIN_W-1:0] load_min;
  logic [1:0]       blink_sel;

  clock_set_ctrl dut (
    .kh_clk    (kh_clk),
    .reset     (reset),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .sw_24h    (sw_24h),
    .cur_hr    (cur_hr),
    .cur_min   (cur_min),
    .run_en    (run_en),
    .load      (load),
    .load_hr   (load_hr),
    .load_min  (load_min),
    .hr12_mode (hr12_mode),
    .blink_sel (blink_sel),
    .blink_on  (blink_on)
  );

  always #5 kh_clk = ~kh_clk;

  typedef struct {
    logic [HR_W-1:0]  hr;
    logic [MIN_W-1:0] mn;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  bit   pending_run = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge kh_clk) begin
    if (reset && load) begin
      if (exp_q.size() == 0) begin
        check("unexpected_load", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("load_hr", int'(load_hr), int'(e.hr));
        check("load_min", int'(load_min), int'(e.mn));
        check("run_en_during_load", int'(run_en), 0);
        pending_run = 1'b1;
      end
    end else if (pending_run) begin
      check("run_en_after_load", int'(run_en), 1);
      pending_run = 1'b0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge kh_clk);
  endtask

  task automatic press(input bit m, input bit i, input int hold);
    @(negedge kh_clk);
    btn_mode = m;
    btn_inc  = i;
    cycles(hold);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cycles(30);
  endtask

  task automatic push(input int h, input int m);
    exp_t x;
    x.hr = HR_W'(h);
    x.mn = MIN_W'(m);
    exp_q.push_back(x);
  endtask

  bit saw0, saw1;

  initial begin
    cycles(5);
    check("rst_run_en", int'(run_en), 1);
    check("rst_load", int'(load), 0);
    check("rst_blink_sel", int'(blink_sel), 0);
    check("rst_blink_on", int'(blink_on), 1);
    check("rst_hr12", int'(hr12_mode), 0);
    check("rst_load_hr", int'(load_hr), 0);
    reset = 1'b1;
    cycles(5);

    // 9:15 -> inc hr x3 -> 12, inc min x50 -> wraps to 5
    cur_hr = 5'd9;
    cur_min = 6'd15;
    push(12, 5);
    press(1, 0, 30);
    check("sethr_sel", int'(blink_sel), 1);
    check("sethr_run", int'(run_en), 0);
    for (int k = 0; k < 3; k++) press(0, 1, 30);
    press(1, 0, 30);
    check("setmin_sel", int'(blink_sel), 2);
    for (int k = 0; k < 50; k++) press(0, 1, 30);
    press(1, 0, 30);
    check("post_commit_run", int'(run_en), 1);
    check("post_commit_sel", int'(blink_sel), 0);

    // async reset in the middle of SET_MIN
    cur_min = 6'd37;
    press(1, 0, 30);
    press(1, 0, 30);
    check("pre_rst_sel", int'(blink_sel), 2);
    reset = 1'b0;
    #1;
    check("arst_run_en", int'(run_en), 1);
    check("arst_sel", int'(blink_sel), 0);
    check("arst_load", int'(load), 0);
    cycles(3);
    reset = 1'b1;
    cycles(5);
    check("arst_load_min", int'(load_min), 0);
    check("arst_load_hr", int'(load_hr), 0);

    // 12 h wrap 11 -> 0, then 24 h wrap 23 -> 0
    sw_24h = 1'b0;
    cycles(5);
    check("hr12_mode", int'(hr12_mode), 1);
    cur_hr = 5'd11;
    cur_min = 6'd20;
    push(0, 20);
    press(1, 0, 30);
    press(0, 1, 30);
    press(1, 0, 30);
    press(1, 0, 30);
    sw_24h = 1'b1;
    cycles(5);
    check("hr24_mode", int'(hr12_mode), 0);
    cur_hr = 5'd23;
    cur_min = 6'd1;
    push(0, 1);
    press(1, 0, 30);
    press(0, 1, 30);
    press(1, 0, 30);
    press(1, 0, 30);

    // hold inc 1500 ms in SET_MIN from 0: press + 6 repeats
    cur_hr = 5'd3;
    cur_min = 6'd0;
    push(3, 7);
    press(1, 0, 30);
    press(1, 0, 30);
    press(0, 1, 1500);
    press(1, 0, 30);

    // blink and timeout in SET_HR without a load
    check("run_blink_on", int'(blink_on), 1);
    cur_hr = 5'd7;
    press(1, 0, 30);
    saw0 = 1'b0;
    saw1 = 1'b0;
    for (int k = 0; k < 1200; k++) begin
      @(negedge kh_clk);
      if (blink_on) saw1 = 1'b1;
      else saw0 = 1'b1;
    end
    check("blink_toggles", int'(saw0 && saw1), 1);
    cycles(8750);
    check("before_timeout_run", int'(run_en), 0);
    cycles(100);
    check("timeout_run", int'(run_en), 1);
    check("timeout_sel", int'(blink_sel), 0);

    // 8 ms bounce bursts must not be accepted
    for (int k = 0; k < 5; k++) begin
      btn_mode = 1'b1;
      cycles(8);
      btn_mode = 1'b0;
      cycles(8);
    end
    cycles(50);
    check("bounce_run", int'(run_en), 1);
    check("bounce_sel", int'(blink_sel), 0);

    // simultaneous mode+inc in SET_HR: mode wins, hr stays 4
    cur_hr = 5'd4;
    cur_min = 6'd30;
    push(4, 30);
    press(1, 0, 30);
    press(1, 1, 30);
    check("simul_sel", int'(blink_sel), 2);
    press(1, 0, 30);

    // 24h -> 12h with edit_hr=18 folds to 6
    cur_hr = 5'd18;
    cur_min = 6'd45;
    push(6, 45);
    press(1, 0, 30);
    sw_24h = 1'b0;
    cycles(10);
    press(1, 0, 30);
    press(1, 0, 30);

    cycles(10);
    check("all_loads_seen", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
